// File: rtl/iotdf_stream_if.sv
// iotdf_stream host/sensor bundle: byte stream and config in, result bus out.
// Master is the upstream driver (sensor + host config), slave is the filter.
interface iotdf_stream_if #(
    parameter int W = 128
);
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic [W-1:0] low;
    logic [W-1:0] high;
    logic         busy;
    logic         valid;
    logic [W-1:0] iot_out;

    modport master (
        output in_en, iot_in, fn_sel, low, high,
        input  busy, valid, iot_out
    );

    modport slave (
        input  in_en, iot_in, fn_sel, low, high,
        output busy, valid, iot_out
    );
endinterface

// File: rtl/iotdf_stream.sv
// iotdf_stream: byte-serial word assembler with per-word / per-round filters.
// Results are registered one cycle after the EVAL state.
module iotdf_stream #(
    parameter int WORD_BYTES = 16,
    parameter int ROUND_LOG2 = 3
) (
    input  logic          clk,
    input  logic          rst,
    iotdf_stream_if.slave bus
);
    localparam int W   = 8 * WORD_BYTES;
    localparam int N   = 1 << ROUND_LOG2;
    localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int SW  = W + ROUND_LOG2;

    localparam logic [2:0] FN_MAX   = 3'd1;
    localparam logic [2:0] FN_MIN   = 3'd2;
    localparam logic [2:0] FN_AVG   = 3'd3;
    localparam logic [2:0] FN_EXT   = 3'd4;
    localparam logic [2:0] FN_EXC   = 3'd5;
    localparam logic [2:0] FN_PKMAX = 3'd6;
    localparam logic [2:0] FN_PKMIN = 3'd7;

    localparam logic [BCW-1:0]        BLAST = BCW'(WORD_BYTES - 1);
    localparam logic [ROUND_LOG2-1:0] WLAST = ROUND_LOG2'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        EVAL
    } state_t;

    state_t                state_q, state_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [ROUND_LOG2-1:0] wcnt_q, wcnt_d;
    logic [W-1:0]          word_q, word_d;
    logic [2:0]            fn_q, fn_d;
    logic [W-1:0]          ext_q, ext_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [W-1:0]          peak_q, peak_d;
    logic                  pkv_q, pkv_d;
    logic                  valid_q, valid_d;
    logic [W-1:0]          out_q, out_d;

    logic accept;
    logic first;
    logic eor;
    logic is_max;
    logic take;
    logic beyond;

    assign accept = bus.in_en && (state_q != EVAL);
    assign first  = (wcnt_q == '0);
    assign eor    = (wcnt_q == WLAST);
    assign is_max = (fn_q == FN_MAX) || (fn_q == FN_PKMAX);
    assign take   = is_max ? (word_q > ext_q) : (word_q < ext_q);
    assign beyond = is_max ? (ext_d > peak_q) : (ext_d < peak_q);

    // Next-state: byte assembly, round bookkeeping and filter evaluation.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        word_d  = word_q;
        fn_d    = fn_q;
        ext_d   = ext_q;
        sum_d   = sum_q;
        peak_d  = peak_q;
        pkv_d   = pkv_q;
        valid_d = 1'b0;
        out_d   = out_q;

        case (state_q)
            IDLE, RECV: begin
                if (accept) begin
                    word_d = (word_q << 8) | W'(bus.iot_in);
                    if (bcnt_q == BLAST) begin
                        bcnt_d  = '0;
                        state_d = EVAL;
                    end else begin
                        bcnt_d  = bcnt_q + BCW'(1);
                        state_d = RECV;
                    end
                    if ((bcnt_q == '0) && first) begin
                        fn_d = bus.fn_sel;
                        if (bus.fn_sel != fn_q) begin
                            pkv_d = 1'b0;
                        end
                    end
                end
            end
            EVAL: begin
                state_d = RECV;
                wcnt_d  = wcnt_q + ROUND_LOG2'(1);
                ext_d   = (first || take) ? word_q : ext_q;
                sum_d   = (first ? '0 : sum_q) + SW'(word_q);
                case (fn_q)
                    FN_MAX, FN_MIN: begin
                        if (eor) begin
                            valid_d = 1'b1;
                            out_d   = ext_d;
                        end
                    end
                    FN_AVG: begin
                        if (eor) begin
                            valid_d = 1'b1;
                            out_d   = W'(sum_d >> ROUND_LOG2);
                        end
                    end
                    FN_EXT: begin
                        if ((bus.low < word_q) && (word_q < bus.high)) begin
                            valid_d = 1'b1;
                            out_d   = word_q;
                        end
                    end
                    FN_EXC: begin
                        if ((word_q < bus.low) || (word_q > bus.high)) begin
                            valid_d = 1'b1;
                            out_d   = word_q;
                        end
                    end
                    FN_PKMAX, FN_PKMIN: begin
                        if (eor && (!pkv_q || beyond)) begin
                            valid_d = 1'b1;
                            out_d   = ext_d;
                            peak_d  = ext_d;
                            pkv_d   = 1'b1;
                        end
                    end
                    default: begin
                        valid_d = 1'b0;
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any partial word or round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            word_q  <= '0;
            fn_q    <= '0;
            ext_q   <= '0;
            sum_q   <= '0;
            peak_q  <= '0;
            pkv_q   <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            word_q  <= word_d;
            fn_q    <= fn_d;
            ext_q   <= ext_d;
            sum_q   <= sum_d;
            peak_q  <= peak_d;
            pkv_q   <= pkv_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy    = (state_q == EVAL);
    assign bus.valid   = valid_q;
    assign bus.iot_out = out_q;
endmodule

// File: tb/tb_iotdf_stream.sv
// Bench for iotdf_stream: a 16-byte/8-word instance and a 4-byte/2-word
// instance, both checked against a round-level reference model.
module tb_iotdf_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iotdf_stream_if #(.W(128)) bus_a ();
    iotdf_stream_if #(.W(32))  bus_b ();

    iotdf_stream #(.WORD_BYTES(16), .ROUND_LOG2(3)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    iotdf_stream #(.WORD_BYTES(4), .ROUND_LOG2(1)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    bit           sel;
    logic         en;
    logic [7:0]   din;
    logic [2:0]   fn;
    logic [127:0] lo, hi;

    assign bus_a.in_en  = en & ~sel;
    assign bus_b.in_en  = en & sel;
    assign bus_a.iot_in = din;
    assign bus_b.iot_in = din;
    assign bus_a.fn_sel = fn;
    assign bus_b.fn_sel = fn;
    assign bus_a.low    = lo;
    assign bus_a.high   = hi;
    assign bus_b.low    = lo[31:0];
    assign bus_b.high   = hi[31:0];

    logic         o_busy, o_valid;
    logic [127:0] o_out;
    assign o_busy  = sel ? bus_b.busy  : bus_a.busy;
    assign o_valid = sel ? bus_b.valid : bus_a.valid;
    assign o_out   = sel ? {96'b0, bus_b.iot_out} : bus_a.iot_out;

    int checks   = 0;
    int failures = 0;

    logic [2:0]   cur_fn;
    logic [127:0] rw[8];
    logic [127:0] m_words[2][8];
    int           m_widx[2];
    logic [2:0]   m_fn[2];
    logic [127:0] m_pk[2];
    bit           m_pkv[2];
    logic [127:0] m_last[2];

    function automatic int nbytes();
        return sel ? 4 : 16;
    endfunction

    function automatic int nlog();
        return sel ? 1 : 3;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_widx[i] = 0;
            m_fn[i]   = 3'd0;
            m_pk[i]   = '0;
            m_pkv[i]  = 1'b0;
            m_last[i] = '0;
        end
    endtask

    task automatic model_word(input logic [127:0] w, output bit ev,
                              output logic [127:0] ex);
        int s;
        int nw;
        logic [127:0] mx, mn, l, h;
        logic [135:0] sm;
        bit eor;
        s  = int'(sel);
        nw = 1 << nlog();
        if (m_widx[s] == 0) begin
            if (cur_fn != m_fn[s]) m_pkv[s] = 1'b0;
            m_fn[s] = cur_fn;
        end
        m_words[s][m_widx[s]] = w;
        mx = w;
        mn = w;
        sm = '0;
        for (int j = 0; j <= m_widx[s]; j++) begin
            if (m_words[s][j] > mx) mx = m_words[s][j];
            if (m_words[s][j] < mn) mn = m_words[s][j];
            sm = sm + {8'b0, m_words[s][j]};
        end
        l   = sel ? {96'b0, lo[31:0]} : lo;
        h   = sel ? {96'b0, hi[31:0]} : hi;
        eor = (m_widx[s] == nw - 1);
        ev  = 1'b0;
        ex  = '0;
        case (m_fn[s])
            3'd1: begin ev = eor; ex = mx; end
            3'd2: begin ev = eor; ex = mn; end
            3'd3: begin ev = eor; ex = 128'(sm >> nlog()); end
            3'd4: begin ev = (l < w) && (w < h); ex = w; end
            3'd5: begin ev = (w < l) || (w > h); ex = w; end
            3'd6: begin
                if (eor && (!m_pkv[s] || mx > m_pk[s])) begin
                    ev = 1'b1; ex = mx; m_pk[s] = mx; m_pkv[s] = 1'b1;
                end
            end
            3'd7: begin
                if (eor && (!m_pkv[s] || mn < m_pk[s])) begin
                    ev = 1'b1; ex = mn; m_pk[s] = mn; m_pkv[s] = 1'b1;
                end
            end
            default: ev = 1'b0;
        endcase
        m_widx[s] = (m_widx[s] + 1) % nw;
        if (ev) m_last[s] = ex;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        en  = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [127:0] wi, input int maxgap,
                             input bit poke);
        int wb;
        int gap;
        bit ev;
        logic [127:0] ex, w;
        wb = nbytes();
        w  = wi;
        if (sel) w[127:32] = '0;
        for (int i = 0; i < wb; i++) begin
            gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            en  = 1'b1;
            din = w[(wb-1-i)*8 +: 8];
            fn  = (i == 0 && m_widx[int'(sel)] == 0) ? cur_fn : 3'($urandom);
            @(posedge clk); #1;
            en = 1'b0;
        end
        model_word(w, ev, ex);
        checks++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL eval_cycle busy=%b valid=%b required busy=1 valid=0",
                     o_busy, o_valid);
        end
        if (poke) begin
            en  = 1'b1;
            din = 8'($urandom);
        end
        @(posedge clk); #1;
        en = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== ev) begin
            failures++;
            $display("FAIL result_strobe busy=%b valid=%b required busy=0 valid=%b",
                     o_busy, o_valid, ev);
        end
        checks++;
        if (o_out !== m_last[int'(sel)]) begin
            failures++;
            $display("FAIL result_data fn=%0d got=%h required=%h",
                     cur_fn, o_out, m_last[int'(sel)]);
        end
    endtask

    task automatic run_round(input logic [2:0] f, input int maxgap,
                             input bit poke);
        cur_fn = f;
        for (int i = 0; i < (1 << nlog()); i++) send_word(rw[i], maxgap, poke);
    endtask

    task automatic test_reset();
        logic [127:0] w;
        for (int k = 0; k < 2; k++) begin
            sel = bit'(k);
            #1;
            checks++;
            if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_out !== '0) begin
                failures++;
                $display("FAIL reset_state inst=%0d busy=%b valid=%b out=%h required 0",
                         k, o_busy, o_valid, o_out);
            end
        end
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rw[i] = rnd128();
        run_round(3'd1, 0, 1'b0);
        w  = rnd128();
        fn = 3'd1;
        for (int i = 0; i < 5; i++) begin
            en  = 1'b1;
            din = w[(15-i)*8 +: 8];
            @(posedge clk); #1;
        end
        en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_out !== '0) begin
            failures++;
            $display("FAIL async_reset busy=%b valid=%b out=%h required 0",
                     o_busy, o_valid, o_out);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rw[i] = rnd128();
        run_round(3'd1, 0, 1'b0);
    endtask

    task automatic test_max_min();
        logic [127:0] top;
        logic [7:0] lsb[8];
        lsb = '{8'h01, 8'h08, 8'h03, 8'h05, 8'h02, 8'h07, 8'h04, 8'h06};
        sel = 1'b0;
        do_reset();
        top = rnd128();
        for (int i = 0; i < 8; i++) rw[i] = {top[127:8], lsb[i]};
        run_round(3'd1, 0, 1'b0);
        run_round(3'd2, 0, 1'b0);
        for (int i = 0; i < 8; i++) rw[i] = rnd128();
        run_round(3'd2, 0, 1'b0);
        run_round(3'd1, 0, 1'b0);
    endtask

    task automatic test_avg();
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) rw[i] = 128'(i + 1);
        run_round(3'd3, 0, 1'b0);
        for (int i = 0; i < 8; i++) rw[i] = {128{1'b1}};
        run_round(3'd3, 0, 1'b0);
        for (int i = 0; i < 8; i++) rw[i] = rnd128();
        run_round(3'd3, 0, 1'b0);
    endtask

    task automatic test_band();
        sel = 1'b0;
        do_reset();
        lo = 128'h10;
        hi = 128'h20;
        rw[0] = 128'h10; rw[1] = 128'h15; rw[2] = 128'h20; rw[3] = 128'h30;
        for (int i = 4; i < 8; i++) rw[i] = 128'($urandom_range(0, 63));
        run_round(3'd4, 0, 1'b0);
        run_round(3'd5, 0, 1'b0);
        lo = 128'h40;
        hi = 128'h40;
        rw[0] = 128'h40;
        run_round(3'd4, 0, 1'b0);
        run_round(3'd5, 0, 1'b0);
        lo = 128'h50;
        hi = 128'h30;
        run_round(3'd4, 0, 1'b0);
        run_round(3'd5, 0, 1'b0);
    endtask

    task automatic test_peak();
        logic [127:0] mx[3];
        mx = '{128'h50, 128'h40, 128'h60};
        sel = 1'b0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) rw[i] = 128'($urandom_range(0, 32'(mx[r]) - 1));
            rw[$urandom_range(0, 7)] = mx[r];
            run_round(3'd6, 0, 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) rw[i] = rnd128();
            run_round(3'd7, 0, 1'b0);
        end
        run_round(3'd0, 0, 1'b0);
    endtask

    task automatic test_gaps();
        sel = 1'b1;
        do_reset();
        for (int r = 0; r < 12; r++) begin
            lo = 128'($urandom);
            hi = 128'($urandom);
            rw[0] = rnd128();
            rw[1] = rnd128();
            run_round(3'($urandom_range(0, 7)), 2, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            sel = bit'(k);
            do_reset();
            for (int r = 0; r < 6; r++) begin
                lo = rnd128();
                hi = rnd128();
                for (int i = 0; i < 8; i++) rw[i] = rnd128();
                run_round(3'($urandom_range(0, 7)), 0, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        fn  = '0;
        lo  = '0;
        hi  = '0;
        sel = 1'b0;
        cur_fn = '0;
        model_reset();
        test_reset();
        test_max_min();
        test_avg();
        test_band();
        test_peak();
        test_gaps();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
